matrix_result_writer: RTL and testbench
=======================================

# matrix_result_writer

Downstream stage of the matrix-multiply sequencer. When the sequencer signals that a row pass is complete, this block captures the CORE_COUNT core accumulators in one cycle. It then writes them one lane per beat into the result memory through a valid/ready write port, computing each row-major result address. It skips lanes beyond the second matrix's column count and flags any capture it cannot accept.

## Interface
Parameters:
- CORE_COUNT, 4, number of MAC cores / accumulator lanes
- ACC_W, 32, accumulator width per lane
- OUT_W, 16, stored result width
- ADDR_W, 10, result memory address width

Ports:
- CLOCK_25  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_capture  in  1  one-cycle pulse: accumulators final for (i_row_adr, i_core_column)
- i_acc  in  CORE_COUNT*ACC_W  lane k at bits [k*ACC_W +: ACC_W]; lane k is result column i_core_column+k
- i_row_adr  in  5  result row of the batch (sequencer's pipelined row address)
- i_core_column  in  5  first result column of the batch (sequencer's pipelined core column)
- i_s_matrix_column_size  in  8  result matrix column count; held static while busy
- o_wr_en  out  1  write beat valid
- o_wr_adr  out  ADDR_W  result address
- o_wr_data  out  OUT_W  result value
- i_wr_ready  in  1  memory accepts the beat when o_wr_en && i_wr_ready
- o_busy  out  1  batch held or draining
- o_overflow  out  1  sticky: a capture was dropped
- o_write_count  out  16  beats accepted since reset, wraps at 2^16

## Operation
- Reset values: o_wr_en=0, o_wr_adr=0, o_wr_data=0, o_busy=0, o_overflow=0, o_write_count=0, state IDLE, lane index 0.
- States: IDLE and DRAIN.
- Capture (in IDLE):
  - Latch all lanes.
  - base = i_row_adr*i_s_matrix_column_size + i_core_column. Compute at full 13-bit width, then truncate to ADDR_W (modulo wrap).
  - n = min(CORE_COUNT, i_s_matrix_column_size − i_core_column).
  - If i_core_column ≥ i_s_matrix_column_size, n=0: nothing latched, state stays IDLE, no beat issued.
  - Otherwise go to DRAIN with lane k=0.
- DRAIN:
  - Drive o_wr_en=1, o_wr_adr=base+k (mod 2^ADDR_W), o_wr_data=conv(lane k).
  - On a handshake: k increments and o_write_count increments.
  - A handshake with k=n−1 ends the batch and the state returns to IDLE.
  - Without i_wr_ready, all outputs hold stable.
- conv (default): lower OUT_W bits of the accumulator (two's-complement truncation).
- Capture while in DRAIN: the batch is dropped and o_overflow is set.
  - Exception: a capture in the same cycle as the final handshake is accepted; the next batch starts with no idle cycle.
- o_overflow clears only on rst.
- rst during DRAIN: the batch is abandoned immediately and all outputs return to their reset values on the next edge.

## Timing
- Capture at edge N: o_wr_en=1 from cycle N+1 with lane 0; o_busy=1 from N+1.
- Throughput with i_wr_ready held high: one beat per cycle; an n-lane batch occupies cycles N+1..N+n.
- o_busy deasserts in the cycle after the final handshake, unless a back-to-back capture was accepted.
- o_wr_adr and o_wr_data are registered outputs, with no combinational path from i_wr_ready to o_wr_adr or o_wr_data.
- o_wr_en drops in the cycle after the final handshake, since it is registered.
- Minimum spacing between captures without overflow: n+1 cycles, or n cycles when aligned to the final handshake.

## Configuration
- MATRIX_RESULT_SATURATE_EN defined: conv clamps a signed ACC_W value to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- MATRIX_RESULT_SATURATE_EN undefined: conv is plain truncation.
- Addressing, handshake and timing are identical in both builds.

## Structure
- Shared package matrix_pkg holds:
  - the IDLE/DRAIN state enum;
  - the default CORE_COUNT, ACC_W, OUT_W and ADDR_W constants, shared with the sequencer and cores.
- One sub-module: matrix_result_conv. It is the combinational ACC_W→OUT_W conversion, and it alone contains the MATRIX_RESULT_SATURATE_EN branch.
- Lane buffer, address generator, FSM and counters live in the top module.

## Test plan
- Basic batch: CORE_COUNT=4, s_cols=8, row=2, core_column=4, lanes 10,11,12,13, ready=1 → beats at addr 20,21,22,23 with data 10..13 on cycles N+1..N+4; o_write_count=4.
- Partial batch: s_cols=6, core_column=4 → exactly 2 beats (addr base+0, base+1); lanes 2–3 never written. core_column=8 with s_cols=8 → no beat, o_busy stays 0.
- Backpressure: i_wr_ready toggling 1,0,0,1,… → address/data held during stalls; every beat written exactly once, in order.
- Overflow and back-to-back: capture while on lane 1 → dropped, o_overflow=1 and sticky. Capture exactly on the final-handshake cycle → accepted, next batch's lane 0 follows with no gap, o_overflow unchanged.
- Conversion: lane = 0x0001_2345 → 0x2345 without the macro; 0x7FFF with MATRIX_RESULT_SATURATE_EN. Lane = 0xFFFF_0000 → 0x0000 without, 0x8000 with.
- Reset mid-drain: assert rst on lane 2 → next cycle o_wr_en=0, o_busy=0, o_overflow=0, o_write_count=0; a fresh capture then behaves as the basic batch.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix-multiply datapath: result-writer state
// encoding and the default lane/width constants used by sequencer, cores and writer.
package matrix_pkg;

  localparam int MATRIX_CORE_COUNT = 4;
  localparam int MATRIX_ACC_W      = 32;
  localparam int MATRIX_OUT_W      = 16;
  localparam int MATRIX_ADDR_W     = 10;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } wr_state_e;

endpackage

// File: rtl/matrix_result_conv.sv
// Combinational accumulator-to-result conversion. Plain two's-complement truncation
// by default; clamps to the signed OUT_W range when MATRIX_RESULT_SATURATE_EN is defined.
module matrix_result_conv #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 16
) (
  input  logic [ACC_W-1:0] acc_i,
  output logic [OUT_W-1:0] res_o
);

`ifdef MATRIX_RESULT_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic [OUT_W-1:0] sat_conv(input logic signed [ACC_W-1:0] a);
    if (a > SAT_MAX) begin
      return SAT_MAX[OUT_W-1:0];
    end else if (a < SAT_MIN) begin
      return SAT_MIN[OUT_W-1:0];
    end
    return a[OUT_W-1:0];
  endfunction

  logic signed [ACC_W-1:0] acc_s;
  assign acc_s = acc_i;
  assign res_o = sat_conv(acc_s);
`else
  function automatic logic [OUT_W-1:0] trunc_conv(input logic signed [ACC_W-1:0] a);
    return OUT_W'(a);
  endfunction

  logic signed [ACC_W-1:0] acc_s;
  assign acc_s = acc_i;
  assign res_o = trunc_conv(acc_s);
`endif

endmodule

// File: rtl/matrix_result_writer.sv
// Captures CORE_COUNT accumulators per row pass and drains them one lane per beat
// into result memory at row-major addresses. Conversion build option: MATRIX_RESULT_SATURATE_EN.
module matrix_result_writer
  import matrix_pkg::*;
#(
  parameter int CORE_COUNT = MATRIX_CORE_COUNT,
  parameter int ACC_W      = MATRIX_ACC_W,
  parameter int OUT_W      = MATRIX_OUT_W,
  parameter int ADDR_W     = MATRIX_ADDR_W
) (
  input  logic                        CLOCK_25,
  input  logic                        rst,
  input  logic                        i_capture,
  input  logic [CORE_COUNT*ACC_W-1:0] i_acc,
  input  logic [4:0]                  i_row_adr,
  input  logic [4:0]                  i_core_column,
  input  logic [7:0]                  i_s_matrix_column_size,
  output logic                        o_wr_en,
  output logic [ADDR_W-1:0]           o_wr_adr,
  output logic [OUT_W-1:0]            o_wr_data,
  input  logic                        i_wr_ready,
  output logic                        o_busy,
  output logic                        o_overflow,
  output logic [15:0]                 o_write_count
);

  localparam int CNT_W = $clog2(CORE_COUNT + 1);

  wr_state_e                   state_q;
  logic [CNT_W-1:0]            k_q;
  logic [CNT_W-1:0]            n_q;
  logic [CORE_COUNT*ACC_W-1:0] lanes_q;
  logic                        wr_en_q;
  logic [ADDR_W-1:0]           wr_adr_q;
  logic [OUT_W-1:0]            wr_data_q;
  logic                        busy_q;
  logic                        ovf_q;
  logic [15:0]                 cnt_q;

  logic [12:0]       base_full_d;
  logic [ADDR_W-1:0] base_d;
  logic [7:0]        diff_d;
  logic              valid_d;
  logic [CNT_W-1:0]  n_d;
  logic              hs_d;
  logic              last_d;
  logic              accept_d;
  int                lane_sel_d;
  logic [ACC_W-1:0]  conv_in_d;
  logic [OUT_W-1:0]  conv_out_d;

  // Batch geometry: row-major base address and number of in-range lanes.
  always_comb begin
    base_full_d = 13'(i_row_adr) * 13'(i_s_matrix_column_size) + 13'(i_core_column);
    base_d      = ADDR_W'(base_full_d);
    valid_d     = {3'b000, i_core_column} < i_s_matrix_column_size;
    diff_d      = i_s_matrix_column_size - {3'b000, i_core_column};
    n_d         = (32'(diff_d) >= CORE_COUNT) ? CNT_W'(CORE_COUNT) : diff_d[CNT_W-1:0];
  end

  // A capture landing on the final handshake starts the next batch with no gap.
  always_comb begin
    hs_d     = (state_q == DRAIN) && i_wr_ready;
    last_d   = hs_d && (k_q == n_q - 1'b1);
    accept_d = i_capture && valid_d && ((state_q == IDLE) || last_d);
    lane_sel_d = int'(k_q) + 1;
    if (lane_sel_d >= CORE_COUNT) begin
      lane_sel_d = 0;
    end
    conv_in_d = accept_d ? i_acc[ACC_W-1:0] : lanes_q[lane_sel_d*ACC_W +: ACC_W];
  end

  matrix_result_conv #(
    .ACC_W(ACC_W),
    .OUT_W(OUT_W)
  ) u_conv (
    .acc_i(conv_in_d),
    .res_o(conv_out_d)
  );

  always_ff @(posedge CLOCK_25) begin
    if (accept_d) begin
      lanes_q <= i_acc;
    end
  end

  always_ff @(posedge CLOCK_25) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      n_q       <= '0;
      wr_en_q   <= 1'b0;
      wr_adr_q  <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (hs_d) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (i_capture && (state_q == DRAIN) && !last_d) begin
        ovf_q <= 1'b1;
      end
      if (accept_d) begin
        state_q   <= DRAIN;
        k_q       <= '0;
        n_q       <= n_d;
        wr_en_q   <= 1'b1;
        busy_q    <= 1'b1;
        wr_adr_q  <= base_d;
        wr_data_q <= conv_out_d;
      end else if (last_d) begin
        state_q <= IDLE;
        wr_en_q <= 1'b0;
        busy_q  <= 1'b0;
      end else if (hs_d) begin
        k_q       <= k_q + 1'b1;
        wr_adr_q  <= wr_adr_q + 1'b1;
        wr_data_q <= conv_out_d;
      end
    end
  end

  assign o_wr_en       = wr_en_q;
  assign o_wr_adr      = wr_adr_q;
  assign o_wr_data     = wr_data_q;
  assign o_busy        = busy_q;
  assign o_overflow    = ovf_q;
  assign o_write_count = cnt_q;

endmodule

// File: tb/tb_matrix_result_writer.sv
// Bench for matrix_result_writer: directed scenarios plus randomized traffic against
// a queue-based model of expected write beats.
module tb_matrix_result_writer;
  import matrix_pkg::*;

  localparam int CC = MATRIX_CORE_COUNT;
  localparam int AW = MATRIX_ACC_W;
  localparam int OW = MATRIX_OUT_W;
  localparam int DW = MATRIX_ADDR_W;

  logic                CLOCK_25 = 1'b0;
  logic                rst;
  logic                i_capture;
  logic [CC*AW-1:0]    i_acc;
  logic [4:0]          i_row_adr;
  logic [4:0]          i_core_column;
  logic [7:0]          i_s_matrix_column_size;
  logic                o_wr_en;
  logic [DW-1:0]       o_wr_adr;
  logic [OW-1:0]       o_wr_data;
  logic                i_wr_ready;
  logic                o_busy;
  logic                o_overflow;
  logic [15:0]         o_write_count;

  matrix_result_writer dut (
    .CLOCK_25(CLOCK_25),
    .rst(rst),
    .i_capture(i_capture),
    .i_acc(i_acc),
    .i_row_adr(i_row_adr),
    .i_core_column(i_core_column),
    .i_s_matrix_column_size(i_s_matrix_column_size),
    .o_wr_en(o_wr_en),
    .o_wr_adr(o_wr_adr),
    .o_wr_data(o_wr_data),
    .i_wr_ready(i_wr_ready),
    .o_busy(o_busy),
    .o_overflow(o_overflow),
    .o_write_count(o_write_count)
  );

  always #5 CLOCK_25 = ~CLOCK_25;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int addr;
    int data;
  } beat_t;

  beat_t       exp_q[$];
  logic        m_ovf;
  logic [15:0] m_cnt;
  logic        m_rst;

  function automatic int conv_ref(input logic [31:0] a);
    longint v;
    v = longint'($signed(a));
`ifdef MATRIX_RESULT_SATURATE_EN
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`endif
    return int'(v & 64'hFFFF);
  endfunction

  function automatic logic [CC*AW-1:0] mk(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  // Predict the effect of the coming rising edge from the inputs now applied.
  task automatic model_step(input logic cap, input int row, input int ccol, input int scols,
                            input logic [CC*AW-1:0] acc, input logic rdy, input logic rs);
    int  pend;
    int  n;
    bit  hs;
    bit  last;
    beat_t b;
    if (rs) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_cnt = 16'd0;
      m_rst = 1'b1;
      return;
    end
    m_rst = 1'b0;
    pend  = exp_q.size();
    hs    = (pend > 0) && rdy;
    last  = hs && (pend == 1);
    if (hs) begin
      void'(exp_q.pop_front());
      m_cnt = m_cnt + 16'd1;
    end
    if (cap) begin
      if (pend == 0 || last) begin
        n = (ccol >= scols) ? 0 : ((scols - ccol) < CC ? (scols - ccol) : CC);
        for (int k = 0; k < n; k++) begin
          b.addr = (row * scols + ccol + k) % (1 << DW);
          b.data = conv_ref(acc[k*AW +: AW]);
          exp_q.push_back(b);
        end
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    check("wr_en", 32'(o_wr_en), 32'(exp_q.size() > 0));
    check("busy", 32'(o_busy), 32'(exp_q.size() > 0));
    check("overflow", 32'(o_overflow), 32'(m_ovf));
    check("write_count", 32'(o_write_count), 32'(m_cnt));
    if (exp_q.size() > 0) begin
      check("wr_adr", 32'(o_wr_adr), 32'(exp_q[0].addr));
      check("wr_data", 32'(o_wr_data), 32'(exp_q[0].data));
    end
    if (m_rst) begin
      check("rst_wr_adr", 32'(o_wr_adr), 32'd0);
      check("rst_wr_data", 32'(o_wr_data), 32'd0);
    end
  endtask

  task automatic cycle(input logic cap, input int row, input int ccol, input int scols,
                       input logic [CC*AW-1:0] acc, input logic rdy, input logic rs);
    i_capture              = cap;
    i_row_adr              = 5'(row);
    i_core_column          = 5'(ccol);
    i_s_matrix_column_size = 8'(scols);
    i_acc                  = acc;
    i_wr_ready             = rdy;
    rst                    = rs;
    model_step(cap, row, ccol, scols, acc, rdy, rs);
    @(posedge CLOCK_25);
    @(negedge CLOCK_25);
    compare_all();
  endtask

  task automatic idle(input int cycles, input logic rdy);
    for (int i = 0; i < cycles; i++) begin
      cycle(1'b0, 0, 0, 8, '0, rdy, 1'b0);
    end
  endtask

  logic [CC*AW-1:0] basic;
  logic [1:0]       rdy_pat;

  initial begin
    basic = mk(10, 11, 12, 13);
    i_capture = 1'b0; i_acc = '0; i_row_adr = '0; i_core_column = '0;
    i_s_matrix_column_size = 8'd8; i_wr_ready = 1'b1; rst = 1'b1;
    exp_q.delete(); m_ovf = 1'b0; m_cnt = 16'd0; m_rst = 1'b1;

    cycle(1'b0, 0, 0, 8, '0, 1'b1, 1'b1);
    cycle(1'b0, 0, 0, 8, '0, 1'b1, 1'b1);

    // Basic batch: addresses 20..23, data 10..13.
    cycle(1'b1, 2, 4, 8, basic, 1'b1, 1'b0);
    idle(5, 1'b1);
    check("basic_count", 32'(o_write_count), 32'd4);

    // Partial batch, then an out-of-range column.
    cycle(1'b1, 1, 4, 6, mk(5, 6, 7, 8), 1'b1, 1'b0);
    idle(4, 1'b1);
    cycle(1'b1, 3, 8, 8, mk(1, 2, 3, 4), 1'b1, 1'b0);
    idle(2, 1'b1);
    check("partial_count", 32'(o_write_count), 32'd6);

    // Backpressure with ready pattern 1,0,0,1,...
    cycle(1'b1, 5, 0, 30, mk(100, 200, 300, 400), 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) begin
      rdy_pat = 2'(i % 3);
      cycle(1'b0, 0, 0, 8, '0, rdy_pat == 2'd0, 1'b0);
    end

    // Conversion corner values.
    cycle(1'b1, 0, 0, 8, mk(32'h0001_2345, 32'hFFFF_0000, 32'h7FFF_FFFF, 32'h8000_0000), 1'b1, 1'b0);
    idle(5, 1'b1);

    // Capture while on lane 1 is dropped.
    cycle(1'b1, 2, 4, 8, basic, 1'b1, 1'b0);
    cycle(1'b0, 0, 0, 8, '0, 1'b1, 1'b0);
    cycle(1'b1, 7, 0, 8, mk(9, 9, 9, 9), 1'b1, 1'b0);
    idle(3, 1'b1);
    check("overflow_set", 32'(o_overflow), 32'd1);

    // Capture on the final handshake is accepted with no gap.
    cycle(1'b1, 1, 0, 16, mk(21, 22, 23, 24), 1'b1, 1'b0);
    idle(3, 1'b1);
    cycle(1'b1, 3, 4, 16, mk(31, 32, 33, 34), 1'b1, 1'b0);
    idle(5, 1'b1);

    // Reset while lane 2 is on the port, then a fresh basic batch.
    cycle(1'b1, 2, 4, 8, basic, 1'b1, 1'b0);
    idle(2, 1'b1);
    cycle(1'b0, 0, 0, 8, '0, 1'b1, 1'b1);
    check("rst_count", 32'(o_write_count), 32'd0);
    cycle(1'b1, 2, 4, 8, basic, 1'b1, 1'b0);
    idle(5, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [CC*AW-1:0] acc_r;
      for (int k = 0; k < CC; k++) begin
        acc_r[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 70000)) - 32'd35000
                                                        : 32'($urandom);
      end
      cycle($urandom_range(0, 3) == 0, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 40)), acc_r, $urandom_range(0, 2) != 0,
            $urandom_range(0, 149) == 0);
    end
    idle(8, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
